// File: rtl/quat_normalize.sv
// Quaternion normaliser: sum of squares -> external inverse-sqrt unit -> per-component scale.
// Optional define QUAT_NORM_ROUND_EN selects round-half-up instead of truncation.
module quat_normalize #(
    parameter int INT_WIDTH   = 4,
    parameter int FRACT_WIDTH = 12
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [4*(INT_WIDTH+FRACT_WIDTH)-1:0]     q_in,
    input  logic                                     valid_in,
    output logic                                     ready_in,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]         isq_data,
    output logic                                     isq_valid,
    input  logic                                     isq_ready,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]         isq_result,
    input  logic                                     isq_result_valid,
    output logic                                     isq_result_ready,
    output logic [4*(INT_WIDTH+FRACT_WIDTH)-1:0]     q_out,
    output logic                                     valid_out,
    input  logic                                     ready_out,
    output logic                                     zero_norm,
    output logic                                     sat
);

    localparam int W     = INT_WIDTH + FRACT_WIDTH;
    localparam int MUL_W = 2 * W + 2;
    localparam int SH_W  = MUL_W - FRACT_WIDTH;

    localparam logic [SH_W-1:0]        UMAX = SH_W'((1 << W) - 1);
    localparam logic signed [SH_W-1:0] SMAX = SH_W'((1 << (W - 1)) - 1);
    localparam logic signed [SH_W-1:0] SMIN = ~SMAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_CHECK,
        S_REQ,
        S_WAIT,
        S_SCALE,
        S_OUT
    } state_t;

    state_t                  state;
    logic [1:0]              idx;
    logic signed [W-1:0]     comp [4];
    logic signed [MUL_W-1:0] acc;
    logic [W-1:0]            inv;

    logic signed [W:0]       mul_a;
    logic signed [W:0]       mul_b;
    logic signed [MUL_W-1:0] product;
    logic [SH_W-1:0]         sum_chk;
    logic [W:0]              scaled;

    // Accumulated sum of squares is never negative, so the shift is a plain divide.
    function automatic logic [SH_W-1:0] acc_shift(input logic signed [MUL_W-1:0] a);
        logic signed [MUL_W-1:0] r;
`ifdef QUAT_NORM_ROUND_EN
        r = a + $signed(MUL_W'(1 << (FRACT_WIDTH - 1)));
`else
        r = a;
`endif
        acc_shift = SH_W'(r >>> FRACT_WIDTH);
    endfunction

    // Returns {clipped, value}; the arithmetic shift floors toward -inf.
    function automatic logic [W:0] scale_sat(input logic signed [MUL_W-1:0] p);
        logic signed [MUL_W-1:0] r;
        logic signed [SH_W-1:0]  s;
`ifdef QUAT_NORM_ROUND_EN
        r = p + $signed(MUL_W'(1 << (FRACT_WIDTH - 1)));
`else
        r = p;
`endif
        s = $signed(SH_W'(r >>> FRACT_WIDTH));
        if (s > SMAX)
            scale_sat = {1'b1, SMAX[W-1:0]};
        else if (s < SMIN)
            scale_sat = {1'b1, SMIN[W-1:0]};
        else
            scale_sat = {1'b0, s[W-1:0]};
    endfunction

    // Single shared multiplier: squares during SQUARE, comp * 1/|q| during SCALE.
    always_comb begin
        mul_a   = {comp[idx][W-1], comp[idx]};
        mul_b   = (state == S_SCALE) ? $signed({1'b0, inv}) : mul_a;
        product = mul_a * mul_b;
        sum_chk = acc_shift(acc);
        scaled  = scale_sat(product);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            idx              <= '0;
            acc              <= '0;
            inv              <= '0;
            for (int i = 0; i < 4; i++) comp[i] <= '0;
            ready_in         <= 1'b0;
            isq_data         <= '0;
            isq_valid        <= 1'b0;
            isq_result_ready <= 1'b0;
            q_out            <= '0;
            valid_out        <= 1'b0;
            zero_norm        <= 1'b0;
            sat              <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_in <= 1'b1;
                    if (valid_in && ready_in) begin
                        for (int i = 0; i < 4; i++) comp[i] <= q_in[(3 - i) * W +: W];
                        acc       <= '0;
                        idx       <= '0;
                        ready_in  <= 1'b0;
                        zero_norm <= 1'b0;
                        sat       <= 1'b0;
                        state     <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    acc <= acc + product;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) state <= S_CHECK;
                end
                S_CHECK: begin
                    if (sum_chk > UMAX) begin
                        isq_data  <= '1;
                        sat       <= 1'b1;
                        isq_valid <= 1'b1;
                        state     <= S_REQ;
                    end else if (sum_chk == '0) begin
                        q_out     <= {W'(1 << FRACT_WIDTH), {(3 * W){1'b0}}};
                        zero_norm <= 1'b1;
                        valid_out <= 1'b1;
                        state     <= S_OUT;
                    end else begin
                        isq_data  <= sum_chk[W-1:0];
                        isq_valid <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (isq_ready) begin
                        isq_valid        <= 1'b0;
                        isq_result_ready <= 1'b1;
                        state            <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (isq_result_valid) begin
                        inv              <= isq_result;
                        isq_result_ready <= 1'b0;
                        idx              <= '0;
                        state            <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    q_out[(3 - int'(idx)) * W +: W] <= scaled[W-1:0];
                    if (scaled[W]) sat <= 1'b1;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        valid_out <= 1'b1;
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (ready_out) begin
                        valid_out <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
